cpu_decode: RTL and testbench
=============================

# cpu_decode

Instruction decode stage between the fetch unit's instruction FIFO and execute. Accepts one 16-bit moxie opcode (plus its pre-fetched 32-bit operand word) per cycle, splits it into form, operation, register fields and a resolved immediate, and presents the result in a pipeline register to execute. A 16-entry register scoreboard stalls issue while a source or destination register has an outstanding write. Stall is propagated back to fetch.

## Interface
- No parameters.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `opcode_i`  in  16  instruction halfword from the instruction FIFO.
- `operand_i`  in  32  32-bit immediate word following the opcode; meaningful only for long ops.
- `valid_i`  in  1  `opcode_i`/`operand_i` hold an instruction.
- `stall_o`  out  1  to fetch `stall_i`: current instruction not consumed; fetch holds it.
- `stall_i`  in  1  from execute: output register must hold.
- `wb_en_i`  in  1  execute/writeback retires a register write this cycle.
- `wb_reg_i`  in  4  register retired.
- `valid_o`  out  1  decoded instruction present.
- `form_o`  out  2  0 = form 1, 2 = form 2, 3 = form 3.
- `op_o`  out  8  form 1: `opcode[15:8]`; form 2: `{6'b0,opcode[13:12]}`; form 3: `{4'b0,opcode[13:10]}`.
- `rega_o`, `regb_o`  out  4 each  form 1: `[7:4]`, `[3:0]`; form 2: A = `[11:8]`, B = 0; form 3: both 0.
- `imm_o`  out  32  resolved immediate (see Operation).
- `has_imm_o`  out  1  instruction consumed `operand_i`.
- `wreg_en_o`  out  1  instruction writes `rega_o`.
- `illegal_o`  out  1  form 1 op > 0x39.

## Operation
- Form: `opcode[15]==0` form 1; `[15:14]==2'b10` form 2; `2'b11` form 3.
- Long ops (form 1 `has_imm`): 0x01,0x03,0x08,0x09,0x0c,0x0d,0x1a,0x1b,0x1d,0x1e,0x20,0x22,0x23,0x36,0x37,0x38,0x39.
- `imm_o`: form 1 long = `operand_i`; form 1 short = 0; form 2 = zero-extended `[7:0]`; form 3 = `{{21{o[9]}},o[9:0],1'b0}` with `o = opcode[9:0]`.
- `wreg_en`: form 1 writes A except ops 0x00,0x03,0x04,0x09,0x0b,0x0d,0x0e,0x1a,0x1e,0x1f,0x23,0x24,0x25,0x30,0x35,0x37,0x39, and except illegal ops; form 2 writes A for ops 0..2, not 3; form 3 never.
- Hazard (combinational on input): form 1 `pending[A]|pending[B]`; form 2 `pending[A]`; form 3 none.
- Accept = `valid_i & ~rst_i & ~hazard & ~(valid_o & stall_i)`.
- `stall_o = rst_i | (valid_i & ~accept)`.
- Output register: if `valid_o & stall_i`, hold all fields. Else `valid_o <= accept` and fields load from decoded input; on non-accept, `valid_o` drops to 0 (bubble).
- Scoreboard `pending[15:0]`: on accept with `wreg_en`, set bit A; on `wb_en_i`, clear bit `wb_reg_i`. Same-cycle set and clear of the same register: set wins.
- Illegal ops pass through with `illegal_o=1`, no scoreboard effect, no hazard check beyond form 1 rule.

## Timing
- Reset: `valid_o`,`form_o`,`op_o`,`rega_o`,`regb_o`,`imm_o`,`has_imm_o`,`wreg_en_o`,`illegal_o` = 0; `pending` = 0; `stall_o` = 1 while `rst_i` high. Reset mid-stall discards held instruction and all pending bits.
- Latency 1: instruction accepted at edge N is on outputs after edge N.
- Throughput one instruction per cycle with no hazard and no downstream stall.
- Hazard clears in the cycle after `wb_en_i` edge (scoreboard is registered; no writeback bypass).
- `stall_i` with `valid_o=0` is ignored (bubble can be overwritten).

## Test plan
- Reset: hold `rst_i` 2 cycles with `valid_i=1` -> all outputs 0, `stall_o=1`; release -> first opcode accepted next edge.
- Long op: `opcode_i=0x0120` (ldi.l $r2), `operand_i=0xDEADBEEF` -> `form_o=0`, `op_o=0x01`, `rega_o=2`, `imm_o=0xDEADBEEF`, `has_imm_o=1`, `wreg_en_o=1`, pending[2] set.
- Form 2/3: `0x8305` (inc $r3,5) -> `form_o=2`, `op_o=0`, `rega_o=3`, `imm_o=5`; `0xC3FF` -> `form_o=3`, `op_o=0`, `imm_o=0xFFFFFFFE`, `wreg_en_o=0`.
- RAW hazard: ldi.l $r2 then `0x0512` (add $r1,$r2) -> `stall_o=1`, `valid_o=0` after ldi.l; pulse `wb_en_i`,`wb_reg_i=2` -> add issues next cycle.
- Downstream stall: `stall_i=1` for 3 cycles with `valid_o=1` -> outputs frozen, `stall_o=1` with `valid_i`; release -> next instruction appears one edge later, none lost or duplicated.
- Illegal/same-cycle: opcode 0x4000 -> `illegal_o=1`, `wreg_en_o=0`; accept write to $r4 with simultaneous `wb_en_i`,`wb_reg_i=4` -> pending[4] remains 1.

Source files
------------

// File: rtl/cpu_decode.sv
// Moxie decode stage: splits a 16-bit opcode into form/op/register fields and a resolved
// immediate, and registers the result for execute. A register scoreboard blocks issue on RAW/WAW hazards.
module cpu_decode (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] opcode_i,
   input  logic [31:0] operand_i,
   input  logic        valid_i,
   output logic        stall_o,
   input  logic        stall_i,
   input  logic        wb_en_i,
   input  logic [3:0]  wb_reg_i,
   output logic        valid_o,
   output logic [1:0]  form_o,
   output logic [7:0]  op_o,
   output logic [3:0]  rega_o,
   output logic [3:0]  regb_o,
   output logic [31:0] imm_o,
   output logic        has_imm_o,
   output logic        wreg_en_o,
   output logic        illegal_o
);

   logic [15:0] pending;
   logic [1:0]  d_form;
   logic [7:0]  d_op;
   logic [3:0]  d_rega, d_regb;
   logic [31:0] d_imm;
   logic        d_has_imm, d_wreg_en, d_illegal, hazard, accept, hold;

   always_comb begin
      d_form    = 2'd0;
      d_op      = 8'd0;
      d_rega    = 4'd0;
      d_regb    = 4'd0;
      d_imm     = 32'd0;
      d_has_imm = 1'b0;
      d_wreg_en = 1'b0;
      d_illegal = 1'b0;
      hazard    = 1'b0;
      if (!opcode_i[15]) begin
         d_form    = 2'd0;
         d_op      = opcode_i[15:8];
         d_rega    = opcode_i[7:4];
         d_regb    = opcode_i[3:0];
         d_illegal = (d_op > 8'h39);
         case (d_op)
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d,
            8'h1e, 8'h20, 8'h22, 8'h23, 8'h36, 8'h37, 8'h38, 8'h39: d_has_imm = 1'b1;
            default: d_has_imm = 1'b0;
         endcase
         case (d_op)
            8'h00, 8'h03, 8'h04, 8'h09, 8'h0b, 8'h0d, 8'h0e, 8'h1a, 8'h1e,
            8'h1f, 8'h23, 8'h24, 8'h25, 8'h30, 8'h35, 8'h37, 8'h39: d_wreg_en = 1'b0;
            default: d_wreg_en = ~d_illegal;
         endcase
         d_imm  = d_has_imm ? operand_i : 32'd0;
         hazard = pending[d_rega] | pending[d_regb];
      end else if (!opcode_i[14]) begin
         d_form    = 2'd2;
         d_op      = {6'd0, opcode_i[13:12]};
         d_rega    = opcode_i[11:8];
         d_imm     = {24'd0, opcode_i[7:0]};
         d_wreg_en = (opcode_i[13:12] != 2'd3);
         hazard    = pending[d_rega];
      end else begin
         d_form = 2'd3;
         d_op   = {4'd0, opcode_i[13:10]};
         d_imm  = {{21{opcode_i[9]}}, opcode_i[9:0], 1'b0};
      end
   end

   assign hold    = valid_o & stall_i;
   assign accept  = valid_i & ~rst_i & ~hazard & ~hold;
   assign stall_o = rst_i | (valid_i & ~accept);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o   <= 1'b0;
         form_o    <= 2'd0;
         op_o      <= 8'd0;
         rega_o    <= 4'd0;
         regb_o    <= 4'd0;
         imm_o     <= 32'd0;
         has_imm_o <= 1'b0;
         wreg_en_o <= 1'b0;
         illegal_o <= 1'b0;
         pending   <= 16'd0;
      end else begin
         if (!hold) begin
            valid_o   <= accept;
            form_o    <= d_form;
            op_o      <= d_op;
            rega_o    <= d_rega;
            regb_o    <= d_regb;
            imm_o     <= d_imm;
            has_imm_o <= d_has_imm;
            wreg_en_o <= d_wreg_en;
            illegal_o <= d_illegal;
         end
         // Set is applied after clear so an issuing writer beats a same-cycle retire.
         begin
            logic [15:0] nxt;
            nxt = pending;
            if (wb_en_i)             nxt[wb_reg_i] = 1'b0;
            if (accept && d_wreg_en) nxt[d_rega]   = 1'b1;
            pending <= nxt;
         end
      end
   end

endmodule

// File: tb/tb_cpu_decode.sv
// Directed test of cpu_decode: reset, decode forms, scoreboard hazards, downstream stall, illegal ops.
module tb_cpu_decode;

   logic        clk = 1'b0;
   logic        rst, valid_i, stall_i, wb_en;
   logic [15:0] opcode;
   logic [31:0] operand;
   logic [3:0]  wb_reg;
   logic        stall_o, valid_o, has_imm_o, wreg_en_o, illegal_o;
   logic [1:0]  form_o;
   logic [7:0]  op_o;
   logic [3:0]  rega_o, regb_o;
   logic [31:0] imm_o;
   int checks = 0;
   int failures = 0;

   cpu_decode dut (
      .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .operand_i(operand), .valid_i(valid_i),
      .stall_o(stall_o), .stall_i(stall_i), .wb_en_i(wb_en), .wb_reg_i(wb_reg),
      .valid_o(valid_o), .form_o(form_o), .op_o(op_o), .rega_o(rega_o), .regb_o(regb_o),
      .imm_o(imm_o), .has_imm_o(has_imm_o), .wreg_en_o(wreg_en_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [1:0] f, input logic [7:0] o,
                          input logic [3:0] a, input logic [3:0] b, input logic [31:0] im,
                          input logic hi, input logic we, input logic il);
      chk({tag, ".valid"}, 32'(valid_o), 32'(v));
      chk({tag, ".form"}, 32'(form_o), 32'(f));
      chk({tag, ".op"}, 32'(op_o), 32'(o));
      chk({tag, ".rega"}, 32'(rega_o), 32'(a));
      chk({tag, ".regb"}, 32'(regb_o), 32'(b));
      chk({tag, ".imm"}, imm_o, im);
      chk({tag, ".has_imm"}, 32'(has_imm_o), 32'(hi));
      chk({tag, ".wreg_en"}, 32'(wreg_en_o), 32'(we));
      chk({tag, ".illegal"}, 32'(illegal_o), 32'(il));
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b1; stall_i = 1'b0; wb_en = 1'b0; wb_reg = 4'd0;
      opcode = 16'h0120; operand = 32'hDEADBEEF;
      // reset with valid input held
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_out("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
         chk("rst.stall_o", 32'(stall_o), 1);
      end
      rst = 1'b0;
      #1 chk("rel.stall_o", 32'(stall_o), 0);
      tick();
      chk_out("ldi", 1, 0, 8'h01, 2, 0, 32'hDEADBEEF, 1, 1, 0);

      // RAW on $r2
      opcode = 16'h0512;
      #1 chk("raw.stall_o", 32'(stall_o), 1);
      tick();
      chk("raw.valid1", 32'(valid_o), 0);
      chk("raw.stall1", 32'(stall_o), 1);
      wb_en = 1'b1; wb_reg = 4'd2;
      tick();
      wb_en = 1'b0;
      chk("raw.valid2", 32'(valid_o), 0);
      #1 chk("raw.stall2", 32'(stall_o), 0);
      tick();
      chk_out("add", 1, 0, 8'h05, 1, 2, 0, 0, 1, 0);

      // form 2, retire $r1 meanwhile
      opcode = 16'h8305; wb_en = 1'b1; wb_reg = 4'd1;
      tick();
      chk_out("inc", 1, 2, 0, 3, 0, 32'd5, 0, 1, 0);
      // form 3, retire $r3
      opcode = 16'hC3FF; wb_reg = 4'd3;
      tick();
      wb_en = 1'b0;
      chk_out("f3", 1, 3, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 0);

      // downstream stall holds the register and back-pressures fetch
      stall_i = 1'b1; opcode = 16'hC001;
      #1 chk("ds.stall_o", 32'(stall_o), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ds.valid", 32'(valid_o), 1);
         chk("ds.imm", imm_o, 32'hFFFFFFFE);
         chk("ds.stall_o", 32'(stall_o), 1);
      end
      stall_i = 1'b0;
      #1 chk("ds.rel_stall", 32'(stall_o), 0);
      tick();
      chk("ds.next_imm", imm_o, 32'd2);
      opcode = 16'hC002;
      tick();
      chk("ds.after_imm", imm_o, 32'd4);
      valid_i = 1'b0;
      tick();
      chk("bubble.valid", 32'(valid_o), 0);

      // stall_i ignored while output is a bubble
      stall_i = 1'b1; valid_i = 1'b1; opcode = 16'hC003;
      #1 chk("bub_ovr.stall_o", 32'(stall_o), 0);
      tick();
      stall_i = 1'b0;
      chk("bub_ovr.valid", 32'(valid_o), 1);
      chk("bub_ovr.imm", imm_o, 32'd6);

      // illegal op
      opcode = 16'h4000;
      tick();
      chk_out("illegal", 1, 0, 8'h40, 0, 0, 0, 0, 0, 1);

      // set wins over same-cycle clear on $r4
      opcode = 16'h0140; operand = 32'h12345678; wb_en = 1'b1; wb_reg = 4'd4;
      tick();
      wb_en = 1'b0;
      chk_out("ldi4", 1, 0, 8'h01, 4, 0, 32'h12345678, 1, 1, 0);
      opcode = 16'h0540;
      #1 chk("setwins.stall_o", 32'(stall_o), 1);
      wb_en = 1'b1; wb_reg = 4'd4;
      tick();
      wb_en = 1'b0;
      chk("setwins.valid", 32'(valid_o), 0);
      tick();
      chk_out("add4", 1, 0, 8'h05, 4, 0, 0, 0, 1, 0);

      // reset mid-stall discards held op and pending $r4
      stall_i = 1'b1; rst = 1'b1;
      tick();
      chk_out("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0; stall_i = 1'b0;
      #1 chk("rst2.stall_o", 32'(stall_o), 0);
      tick();
      chk("rst2.reissue", 32'(valid_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
